// File: rtl/lzw_backward_byte_reverse_if.sv
// Byte-reverse stage bus: upstream recovered-byte/close signals plus the
// downstream forward-order payload stream.
interface lzw_backward_byte_reverse_if;
    logic [7:0] I_recv_data;
    logic       I_recv_data_en;
    logic       I_reverse_byte_flag;
    logic [4:0] I_reverse_byte_num;
    logic       I_reverse_byte_num_wren;
    logic [7:0] O_data;
    logic       O_data_en;
    logic       O_data_last;

    modport master (
        output I_recv_data,
        output I_recv_data_en,
        output I_reverse_byte_flag,
        output I_reverse_byte_num,
        output I_reverse_byte_num_wren,
        input  O_data,
        input  O_data_en,
        input  O_data_last
    );

    modport slave (
        input  I_recv_data,
        input  I_recv_data_en,
        input  I_reverse_byte_flag,
        input  I_reverse_byte_num,
        input  I_reverse_byte_num_wren,
        output O_data,
        output O_data_en,
        output O_data_last
    );
endinterface

// File: rtl/lzw_backward_byte_reverse.sv
// Captures reverse-order LZW strings into two 32-byte ping-pong stacks and replays
// them forward. Optional statistics counters: define LZW_REVERSE_STAT_EN.
module lzw_backward_byte_reverse (
    input  logic                              I_sys_clk,
    input  logic                              I_sys_rst_n,
    input  logic                              I_state_clr,
    lzw_backward_byte_reverse_if.slave        bus,
    output logic                              O_overflow,
    output logic                              O_len_err,
    output logic [31:0]                       O_string_cnt,
    output logic [31:0]                       O_byte_cnt
);

    typedef enum logic [1:0] {
        BANK_FREE,
        BANK_FILL,
        BANK_DRAIN
    } bank_state_e;

    typedef enum logic {
        DRN_IDLE,
        DRN_RUN
    } drain_state_e;

    logic [7:0]   mem_q [2][32];

    bank_state_e  bank_st_q [2];
    bank_state_e  bank_st_d [2];
    logic [4:0]   last_idx_q [2];
    logic [4:0]   last_idx_d [2];
    logic         cap_bank_q, cap_bank_d;
    logic [5:0]   wr_cnt_q, wr_cnt_d;

    drain_state_e drn_st_q, drn_st_d;
    logic         rd_bank_q, rd_bank_d;
    logic [4:0]   rd_ptr_q, rd_ptr_d;

    logic [7:0]   data_q, data_d;
    logic         data_en_q, data_en_d;
    logic         data_last_q, data_last_d;
    logic         ovf_q, ovf_d;
    logic         lerr_q, lerr_d;

    logic         cap_stall;
    logic         byte_ok;
    logic         byte_drop;
    logic         lit_close;
    logic [5:0]   cnt_final;
    logic         close_req;
    logic         close_ok;
    logic         len_mismatch;

    // Capture bank still draining means the previous close is pending: stall.
    always_comb begin
        cap_stall    = (bank_st_q[cap_bank_q] == BANK_DRAIN);
        byte_ok      = bus.I_recv_data_en && !cap_stall && !wr_cnt_q[5];
        byte_drop    = bus.I_recv_data_en && !byte_ok;
        lit_close    = byte_ok && !bus.I_reverse_byte_flag && (wr_cnt_q == 6'd0);
        cnt_final    = wr_cnt_q + {5'd0, byte_ok};
        close_req    = bus.I_reverse_byte_num_wren || lit_close;
        close_ok     = close_req && (cnt_final != 6'd0);
        len_mismatch = bus.I_reverse_byte_num_wren &&
                       ((cnt_final == 6'd0) || ({1'b0, bus.I_reverse_byte_num} != cnt_final));
    end

    always_ff @(posedge I_sys_clk) begin
        if (byte_ok) begin
            mem_q[cap_bank_q][wr_cnt_q[4:0]] <= bus.I_recv_data;
        end
    end

    always_comb begin
        bank_st_d   = bank_st_q;
        last_idx_d  = last_idx_q;
        cap_bank_d  = cap_bank_q;
        wr_cnt_d    = wr_cnt_q;
        drn_st_d    = drn_st_q;
        rd_bank_d   = rd_bank_q;
        rd_ptr_d    = rd_ptr_q;
        data_d      = data_q;
        data_en_d   = 1'b0;
        data_last_d = 1'b0;
        ovf_d       = ovf_q | byte_drop;
        lerr_d      = lerr_q | len_mismatch;

        if (close_ok) begin
            bank_st_d[cap_bank_q]  = BANK_DRAIN;
            last_idx_d[cap_bank_q] = 5'(cnt_final - 6'd1);
            cap_bank_d             = !cap_bank_q;
            wr_cnt_d               = '0;
        end else if (byte_ok) begin
            bank_st_d[cap_bank_q]  = BANK_FILL;
            wr_cnt_d               = cnt_final;
        end

        // Closes always alternate banks, so drains follow rd_bank in close order.
        case (drn_st_q)
            DRN_IDLE: begin
                if (bank_st_q[rd_bank_q] == BANK_DRAIN) begin
                    rd_ptr_d = last_idx_q[rd_bank_q];
                    drn_st_d = DRN_RUN;
                end
            end
            DRN_RUN: begin
                data_d      = mem_q[rd_bank_q][rd_ptr_q];
                data_en_d   = 1'b1;
                data_last_d = (rd_ptr_q == 5'd0);
                if (rd_ptr_q == 5'd0) begin
                    bank_st_d[rd_bank_q] = BANK_FREE;
                    rd_bank_d            = !rd_bank_q;
                    drn_st_d             = DRN_IDLE;
                end else begin
                    rd_ptr_d = rd_ptr_q - 5'd1;
                end
            end
            default: drn_st_d = DRN_IDLE;
        endcase
    end

    always_ff @(posedge I_sys_clk) begin
        if (!I_sys_rst_n) begin
            bank_st_q[0]  <= BANK_FREE;
            bank_st_q[1]  <= BANK_FREE;
            last_idx_q[0] <= '0;
            last_idx_q[1] <= '0;
            cap_bank_q    <= 1'b0;
            wr_cnt_q      <= '0;
            drn_st_q      <= DRN_IDLE;
            rd_bank_q     <= 1'b0;
            rd_ptr_q      <= '0;
            data_q        <= '0;
            data_en_q     <= 1'b0;
            data_last_q   <= 1'b0;
            ovf_q         <= 1'b0;
            lerr_q        <= 1'b0;
        end else begin
            bank_st_q     <= bank_st_d;
            last_idx_q    <= last_idx_d;
            cap_bank_q    <= cap_bank_d;
            wr_cnt_q      <= wr_cnt_d;
            drn_st_q      <= drn_st_d;
            rd_bank_q     <= rd_bank_d;
            rd_ptr_q      <= rd_ptr_d;
            data_q        <= data_d;
            data_en_q     <= data_en_d;
            data_last_q   <= data_last_d;
            ovf_q         <= ovf_d;
            lerr_q        <= lerr_d;
        end
    end

    assign bus.O_data      = data_q;
    assign bus.O_data_en   = data_en_q;
    assign bus.O_data_last = data_last_q;
    assign O_overflow      = ovf_q;
    assign O_len_err       = lerr_q;

`ifdef LZW_REVERSE_STAT_EN
    logic [31:0] str_cnt_q, str_cnt_d;
    logic [31:0] byte_cnt_q, byte_cnt_d;

    always_comb begin
        str_cnt_d  = str_cnt_q  + {31'd0, data_en_q && data_last_q};
        byte_cnt_d = byte_cnt_q + {31'd0, data_en_q};
    end

    always_ff @(posedge I_sys_clk) begin
        if (!I_sys_rst_n || I_state_clr) begin
            str_cnt_q  <= '0;
            byte_cnt_q <= '0;
        end else begin
            str_cnt_q  <= str_cnt_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    assign O_string_cnt = str_cnt_q;
    assign O_byte_cnt   = byte_cnt_q;
`else
    logic unused_state_clr;
    assign unused_state_clr = I_state_clr;
    assign O_string_cnt     = '0;
    assign O_byte_cnt       = '0;
`endif

endmodule
